// File: rtl/hpdcache_data_downsize_partial_if.sv
// Bus bundle for the partial-entry width downsizer: wide write side, narrow read side, occupancy and flush.
interface hpdcache_data_downsize_partial_if #(
  parameter int unsigned WR_WIDTH = 512,
  parameter int unsigned RD_WIDTH = 64,
  parameter int unsigned DEPTH    = 2
);
  localparam int unsigned RD_WORDS = WR_WIDTH / RD_WIDTH;
  localparam int unsigned WCNT_W   = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1;
  localparam int unsigned USED_W   = $clog2(DEPTH + 1);

  logic                flush_i;
  logic                w_i;
  logic                wok_o;
  logic [WR_WIDTH-1:0] wdata_i;
  logic [WCNT_W-1:0]   wfirst_i;
  logic [WCNT_W-1:0]   wcnt_i;
  logic                werr_i;
  logic                r_i;
  logic                rok_o;
  logic [RD_WIDTH-1:0] rdata_o;
  logic                rlast_o;
  logic                rerr_o;
  logic [USED_W-1:0]   used_o;

  modport slave (
    input  flush_i, w_i, wdata_i, wfirst_i, wcnt_i, werr_i, r_i,
    output wok_o, rok_o, rdata_o, rlast_o, rerr_o, used_o
  );

  modport master (
    output flush_i, w_i, wdata_i, wfirst_i, wcnt_i, werr_i, r_i,
    input  wok_o, rok_o, rdata_o, rlast_o, rerr_o, used_o
  );
endinterface

// File: rtl/hpdcache_data_downsize_partial.sv
// Buffers wide entries and replays only their valid word window [first..last] on a narrow read port.
// Optional per-entry error flag: HPDCACHE_DOWNSIZE_ERR_EN. Parameter checks disabled by HPDCACHE_ASSERT_OFF.
module hpdcache_data_downsize_partial #(
  parameter int unsigned WR_WIDTH = 512,
  parameter int unsigned RD_WIDTH = 64,
  parameter int unsigned DEPTH    = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  hpdcache_data_downsize_partial_if.slave bus
);
  localparam int unsigned RD_WORDS = WR_WIDTH / RD_WIDTH;
  localparam int unsigned WCNT_W   = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1;
  localparam int unsigned USED_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IDX_W    = WCNT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RD_WORDS - 1);

`ifndef HPDCACHE_ASSERT_OFF
  if (WR_WIDTH % RD_WIDTH != 0) begin : g_chk_ratio
    $error("WR_WIDTH must be a multiple of RD_WIDTH");
  end
  if (RD_WIDTH >= WR_WIDTH) begin : g_chk_width
    $error("RD_WIDTH must be smaller than WR_WIDTH");
  end
  if (DEPTH < 1) begin : g_chk_depth
    $error("DEPTH must be at least 1");
  end
`endif

  logic [WR_WIDTH-1:0] data_q  [DEPTH];
  logic [WCNT_W-1:0]   first_q [DEPTH];
  logic [WCNT_W-1:0]   last_q  [DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [USED_W-1:0]   used_q, used_d;
  logic [WCNT_W-1:0]   off_q,  off_d;

  logic [IDX_W-1:0]    wfirst_ext, wend_ext;
  logic [WCNT_W-1:0]   wfirst_c, wlast_c;
  logic [WCNT_W-1:0]   rd_word;
  logic                rd_last;
  logic                wok, rok, w_acc, r_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Clamp the incoming word window to the physical entry.
  always_comb begin
    wfirst_ext = IDX_W'(bus.wfirst_i);
    if (wfirst_ext > LAST_IDX) wfirst_ext = LAST_IDX;
    wend_ext = wfirst_ext + IDX_W'(bus.wcnt_i);
    if (wend_ext > LAST_IDX) wend_ext = LAST_IDX;
    wfirst_c = wfirst_ext[WCNT_W-1:0];
    wlast_c  = wend_ext[WCNT_W-1:0];
  end

  assign wok     = (used_q < USED_W'(DEPTH)) & ~bus.flush_i;
  assign rok     = (used_q != '0) & ~bus.flush_i;
  assign w_acc   = bus.w_i & wok;
  assign r_acc   = bus.r_i & rok;
  assign rd_word = first_q[rptr_q] + off_q;
  assign rd_last = (rd_word == last_q[rptr_q]);

  assign bus.wok_o   = wok;
  assign bus.rok_o   = rok;
  assign bus.rdata_o = data_q[rptr_q][32'(rd_word) * RD_WIDTH +: RD_WIDTH];
  assign bus.rlast_o = rok & rd_last;
  assign bus.used_o  = used_q;

`ifdef HPDCACHE_DOWNSIZE_ERR_EN
  logic err_q [DEPTH];
  assign bus.rerr_o = rok & err_q[rptr_q];
`else
  logic unused_werr;
  assign unused_werr = bus.werr_i;
  assign bus.rerr_o  = 1'b0;
`endif

  // Pointer, occupancy and word-offset update; flush overrides everything.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    used_d = used_q;
    off_d  = off_q;
    if (bus.flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      used_d = '0;
      off_d  = '0;
    end else begin
      if (w_acc) wptr_d = ptr_inc(wptr_q);
      if (r_acc) begin
        if (rd_last) begin
          off_d  = '0;
          rptr_d = ptr_inc(rptr_q);
        end else begin
          off_d = off_q + WCNT_W'(1);
        end
      end
      case ({w_acc, r_acc & rd_last})
        2'b10:   used_d = used_q + USED_W'(1);
        2'b01:   used_d = used_q - USED_W'(1);
        default: used_d = used_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      used_q <= '0;
      off_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        first_q[i] <= '0;
        last_q[i]  <= '0;
`ifdef HPDCACHE_DOWNSIZE_ERR_EN
        err_q[i]   <= 1'b0;
`endif
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      used_q <= used_d;
      off_q  <= off_d;
      if (w_acc) begin
        data_q[wptr_q]  <= bus.wdata_i;
        first_q[wptr_q] <= wfirst_c;
        last_q[wptr_q]  <= wlast_c;
`ifdef HPDCACHE_DOWNSIZE_ERR_EN
        err_q[wptr_q]   <= bus.werr_i;
`endif
      end
    end
  end
endmodule

// File: doc/hpdcache_data_downsize_partial.md
HPDCACHE_DATA_DOWNSIZE_PARTIAL -- requirements
Module: hpdcache_data_downsize_partial

Interface
REQ-001 SHALL have parameter WR_WIDTH, default 512: write-side entry width in bits.
REQ-002 SHALL have parameter RD_WIDTH, default 64: read-side word width in bits.
REQ-003 SHALL have parameter DEPTH, default 2: number of buffered entries, >=1.
REQ-004 SHALL derive RD_WORDS=WR_WIDTH/RD_WIDTH and WCNT_W=max(1,clog2(RD_WORDS)).
REQ-005 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port flush_i, input, 1 bit: discard all buffered entries.
REQ-008 SHALL have port w_i, input, 1 bit: write request.
REQ-009 SHALL have port wok_o, output, 1 bit: write ready.
REQ-010 SHALL have port wdata_i, input, WR_WIDTH: write entry.
REQ-011 SHALL have port wfirst_i, input, WCNT_W: index of the first valid word.
REQ-012 SHALL have port wcnt_i, input, WCNT_W: number of valid words minus 1.
REQ-013 SHALL have port werr_i, input, 1 bit: entry error flag.
REQ-014 SHALL have port r_i, input, 1 bit: read request.
REQ-015 SHALL have port rok_o, output, 1 bit: read data valid.
REQ-016 SHALL have port rdata_o, output, RD_WIDTH: current word.
REQ-017 SHALL have port rlast_o, output, 1 bit: current word is the last of its entry.
REQ-018 SHALL have port rerr_o, output, 1 bit: error flag of the current entry.
REQ-019 SHALL have port used_o, output, clog2(DEPTH+1): number of occupied entries.

Function
REQ-020 SHALL accept a write when w_i&wok_o, with wok_o=(used<DEPTH)&~flush_i, registered occupancy only.
REQ-021 SHALL store wdata_i, start index wfirst_i and last index min(wfirst_i+wcnt_i, RD_WORDS-1) per entry; an out-of-range count is truncated to the entry end.
REQ-022 SHALL make a written entry readable the cycle after acceptance; no same-cycle bypass.
REQ-023 SHALL drive rok_o=(used>0)&~flush_i and rdata_o=word[cur] of the head entry, where cur starts at that entry's first index.
REQ-024 SHALL, on r_i&rok_o, advance cur by 1; when cur equals the last index, assert rlast_o, free the entry, and advance the read pointer.
REQ-025 SHALL wrap write and read pointers from DEPTH-1 to 0, DEPTH non-power-of-2 included.
REQ-026 SHALL keep used unchanged on a same-cycle accepted write and last-word read, and SHALL not accept a write when full even if the head is freed that cycle.
REQ-027 SHALL, when flush_i=1, ignore w_i/r_i that cycle and leave used, pointers and cur at 0 on the next cycle; buffer data need not be cleared.
REQ-028 SHALL hold rdata_o, rlast_o and rerr_o stable while rok_o=1 and r_i=0.
REQ-029 SHALL drive rlast_o=0 and rerr_o=0 whenever rok_o=0.

Reset
REQ-030 SHALL, on rst_ni low, asynchronously clear pointers, used, cur and buffer, giving wok_o=1, rok_o=0, rdata_o=0, rlast_o=0, rerr_o=0 and used_o=0.
REQ-031 SHALL drop any partially read entry on reset mid-operation; the first post-reset read returns only data written after reset.

Configuration
REQ-032 SHALL use macro HPDCACHE_DOWNSIZE_ERR_EN: when defined, store werr_i per entry and drive rerr_o with it on every word of that entry.
REQ-033 SHALL, when HPDCACHE_DOWNSIZE_ERR_EN is undefined, leave werr_i unused, store no error state, and tie rerr_o to 0.
REQ-034 SHALL fail elaboration if WR_WIDTH%RD_WIDTH!=0, RD_WIDTH>=WR_WIDTH or DEPTH<1, unless HPDCACHE_ASSERT_OFF is defined.

Verification
REQ-035 SHALL test full entry (WR=256, RD=64): write wfirst=0, wcnt=3, then r_i held high -> four words 0..3 on consecutive cycles, rlast_o on the 4th only, used_o 1->0.
REQ-036 SHALL test a partial entry: wfirst=1, wcnt=1 -> exactly words 1 and 2, rlast_o on word 2; a second test with wfirst=2, wcnt=3 is truncated to words 2..3.
REQ-037 SHALL test full and simultaneous events (DEPTH=2): fill both entries -> wok_o=0, used_o=2; last-word read plus w_i in the same cycle -> write refused, used_o=1.
REQ-038 SHALL test pointer wrap (DEPTH=3): 7 back-to-back entries with random r_i gaps -> read order matches write order and no word is lost.
REQ-039 SHALL test flush: flush_i asserted mid-entry with w_i=1 -> wok_o=rok_o=0 that cycle, used_o=0 next cycle, and the next write is read from its first word.
REQ-040 SHALL test error propagation: with ERR_EN defined, werr_i=1 -> rerr_o=1 on all words of that entry and 0 on the next entry; with ERR_EN undefined, rerr_o=0 throughout.
